// File: rtl/brg_pkg.sv
// ---------------------------------------------------------------------------
// brg_pkg -- shared definitions for the baud-rate generator controller.
//   * counter widths (select, oversample, prescale, bit counters)
//   * default prescale / oversample ratios
//   * reconfiguration FSM state encoding
//   * os_term(): terminal count of the oversample divider for a given select
// ---------------------------------------------------------------------------
package brg_pkg;

    localparam int SEL_W       = 3;
    localparam int OS_CNT_W    = 9;
    localparam int PRE_CNT_W   = 4;
    localparam int BIT_CNT_W   = 5;
    localparam int PRE_DIV_DEF = 3;
    localparam int OVS_DEF     = 8;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_PEND   = 2'b01,
        ST_RELOAD = 2'b10,
        ST_ACK    = 2'b11
    } brg_state_e;

    // Oversample divider terminal value: (2 << sel) - 1, i.e. 1, 3, 7 ... 255.
    // The shift is done at counter width so sel = 7 (256) does not wrap.
    function automatic logic [OS_CNT_W-1:0] os_term(input logic [SEL_W-1:0] sel);
        logic [OS_CNT_W-1:0] span;
        logic [3:0]          shamt;
        shamt = {1'b0, sel} + 4'd1;
        span  = {{(OS_CNT_W-1){1'b0}}, 1'b1} << shamt;
        return span - {{(OS_CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/brg_div_cnt.sv
// ---------------------------------------------------------------------------
// brg_div_cnt -- modulo (term+1) enable counter used for every divider stage.
// Ports:
//   clk   : system clock
//   rst   : asynchronous active-high reset (count -> 0)
//   inc   : count enable (one step per cycle where high)
//   clr   : synchronous clear; wins over inc and suppresses the tick
//   term  : terminal count value; the counter wraps to 0 after it
//   tick  : single-cycle pulse when an enabled step lands on the terminal
// ---------------------------------------------------------------------------
module brg_div_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    input  logic [W-1:0] term,
    output logic         tick
);

    logic [W-1:0] cnt_r;
    logic         at_term_s;

    // Terminal detect and tick pulse; a clearing counter never ticks.
    always_comb begin
        at_term_s = (cnt_r == term);
        tick      = inc & at_term_s & ~clr;
    end

    // Counter state: clear has priority, then wrap-or-increment on enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {W{1'b0}};
        end else if (clr) begin
            cnt_r <= {W{1'b0}};
        end else if (inc) begin
            if (at_term_s) begin
                cnt_r <= {W{1'b0}};
            end else begin
                cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/brg_ctrl.sv
// ---------------------------------------------------------------------------
// brg_ctrl -- UART baud-rate tick generator with safe runtime reconfiguration.
//
// Three cascaded dividers (prescale -> oversample -> bit) produce clock-enable
// pulses on fclk. A four-phase cfg_req/cfg_ack handshake changes the baud
// select; the change is deferred until the UART line is idle.
//
// Ports:
//   fclk       : system clock (only clock in the block)
//   rst        : asynchronous active-high reset
//   en         : tick generation enable; low holds all dividers at zero
//   line_busy  : a UART frame is in progress, defer reconfiguration
//   cfg_req    : reconfiguration request (held until cfg_ack seen)
//   cfg_sel    : requested baud select, sampled only when a request is accepted
//   cfg_ack    : request completed, held until cfg_req drops
//   tick_os    : oversample enable pulse, every PRE_DIV*(2<<cur_sel) cycles
//   tick_bit   : bit-period enable pulse, every OVS tick_os pulses
//   cur_sel    : active baud select
//   cfg_forced : one-cycle pulse when a reload was forced by the wait timeout
//
// Build option: define BRG_CTRL_TIMEOUT_EN to force the reload after
// TIMEOUT_BITS bit periods of a busy line; otherwise the request waits
// indefinitely and cfg_forced is constant 0.
// ---------------------------------------------------------------------------
module brg_ctrl
    import brg_pkg::*;
#(
    parameter int               PRE_DIV      = PRE_DIV_DEF,
    parameter int               OVS          = OVS_DEF,
    parameter logic [SEL_W-1:0] SEL_RST      = 3'b000,
    parameter int               TIMEOUT_BITS = 16
) (
    input  logic             fclk,
    input  logic             rst,
    input  logic             en,
    input  logic             line_busy,
    input  logic             cfg_req,
    input  logic [SEL_W-1:0] cfg_sel,
    output logic             cfg_ack,
    output logic             tick_os,
    output logic             tick_bit,
    output logic [SEL_W-1:0] cur_sel,
    output logic             cfg_forced
);

    localparam logic [PRE_CNT_W-1:0] PRE_TERM = PRE_CNT_W'(PRE_DIV - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_TERM = BIT_CNT_W'(OVS - 1);

    brg_state_e          state_r;
    brg_state_e          next_state_s;
    logic [SEL_W-1:0]    cur_sel_r;
    logic [SEL_W-1:0]    pend_sel_r;
    logic                cfg_ack_r;
    logic                tick_os_r;
    logic                tick_bit_r;
    logic                cfg_forced_r;

    logic                latch_s;
    logic                reload_s;
    logic                forced_s;
    logic                timeout_s;
    logic                clr_s;
    logic                pre_tick_s;
    logic                os_tick_s;
    logic                bit_tick_s;
    logic [OS_CNT_W-1:0] os_term_s;

    // Divider clear: disabled generator or the single reload cycle.
    always_comb begin
        clr_s     = ~en | reload_s;
        os_term_s = os_term(cur_sel_r);
    end

    brg_div_cnt #(.W(PRE_CNT_W)) u_pre_cnt (
        .clk  (fclk),
        .rst  (rst),
        .inc  (en),
        .clr  (clr_s),
        .term (PRE_TERM),
        .tick (pre_tick_s)
    );

    brg_div_cnt #(.W(OS_CNT_W)) u_os_cnt (
        .clk  (fclk),
        .rst  (rst),
        .inc  (pre_tick_s),
        .clr  (clr_s),
        .term (os_term_s),
        .tick (os_tick_s)
    );

    brg_div_cnt #(.W(BIT_CNT_W)) u_bit_cnt (
        .clk  (fclk),
        .rst  (rst),
        .inc  (os_tick_s),
        .clr  (clr_s),
        .term (BIT_TERM),
        .tick (bit_tick_s)
    );

`ifdef BRG_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_BITS + 1);

    logic [TO_W-1:0] to_cnt_r;

    // Bit periods spent waiting in PEND; restarts on every new wait.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if (state_r != ST_PEND) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if (bit_tick_s) begin
            to_cnt_r <= to_cnt_r + TO_W'(1'b1);
        end
    end

    // The bit tick that completes the TIMEOUT_BITS-th period ends the wait.
    always_comb begin
        timeout_s = (state_r == ST_PEND) && bit_tick_s &&
                    (to_cnt_r == TO_W'(TIMEOUT_BITS - 1));
    end
`else
    // No forced reload in this build; TIMEOUT_BITS is referenced only so the
    // parameter stays part of the interface, and the compare is false for any
    // legal value.
    always_comb begin
        timeout_s = (TIMEOUT_BITS < 0);
    end
`endif

    // FSM state register.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; runs independently of en.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (cfg_req) begin
                    next_state_s = ST_PEND;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_PEND: begin
                if (!line_busy || timeout_s) begin
                    next_state_s = ST_RELOAD;
                end else begin
                    next_state_s = ST_PEND;
                end
            end
            ST_RELOAD: begin
                next_state_s = ST_ACK;
            end
            ST_ACK: begin
                if (!cfg_req) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_ACK;
                end
            end
            default: begin
                next_state_s = ST_RUN;
            end
        endcase
    end

    // FSM control outputs: request capture, reload strobe, forced marker.
    always_comb begin
        latch_s  = 1'b0;
        reload_s = 1'b0;
        forced_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                latch_s = cfg_req;
            end
            ST_PEND: begin
                // Forced only when the line is still busy; an idle line takes
                // the normal path even on the timeout tick.
                forced_s = timeout_s & line_busy;
            end
            ST_RELOAD: begin
                reload_s = 1'b1;
            end
            ST_ACK: begin
                latch_s = 1'b0;
            end
            default: begin
                latch_s = 1'b0;
            end
        endcase
    end

    // Registered datapath and outputs.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            cur_sel_r    <= SEL_RST;
            pend_sel_r   <= SEL_RST;
            cfg_ack_r    <= 1'b0;
            tick_os_r    <= 1'b0;
            tick_bit_r   <= 1'b0;
            cfg_forced_r <= 1'b0;
        end else begin
            if (latch_s) begin
                pend_sel_r <= cfg_sel;
            end
            if (reload_s) begin
                cur_sel_r <= pend_sel_r;
            end
            cfg_ack_r    <= (next_state_s == ST_ACK);
            tick_os_r    <= os_tick_s;
            tick_bit_r   <= bit_tick_s;
            cfg_forced_r <= forced_s;
        end
    end

    assign cfg_ack    = cfg_ack_r;
    assign tick_os    = tick_os_r;
    assign tick_bit   = tick_bit_r;
    assign cur_sel    = cur_sel_r;
    assign cfg_forced = cfg_forced_r;

endmodule

// File: tb/tb_brg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_brg_ctrl -- self-checking bench for brg_ctrl.
// A behavioural model tracks elapsed enabled cycles since the last divider
// restart and derives tick timing by modulo arithmetic; the handshake is
// tracked as a request phase. Every cycle all outputs are compared.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_brg_ctrl;

    localparam int         PRE  = 3;
    localparam int         OVSP = 8;
    localparam int         TOB  = 16;
    localparam logic [2:0] SELR = 3'b000;

    logic       fclk      = 1'b0;
    logic       rst       = 1'b0;
    logic       en        = 1'b0;
    logic       line_busy = 1'b0;
    logic       cfg_req   = 1'b0;
    logic [2:0] cfg_sel   = 3'd0;
    logic       cfg_ack;
    logic       tick_os;
    logic       tick_bit;
    logic [2:0] cur_sel;
    logic       cfg_forced;

    int total = 0;
    int bad   = 0;

    // model: phase 0 idle, 1 waiting for idle line, 2 reloading, 3 acknowledging
    int m_phase;
    int m_sel;
    int m_pend;
    int m_elapsed;
    int m_bits_waited;
    bit m_ack;
    bit m_os;
    bit m_bit;
    bit m_forced;

    brg_ctrl #(
        .PRE_DIV      (PRE),
        .OVS          (OVSP),
        .SEL_RST      (SELR),
        .TIMEOUT_BITS (TOB)
    ) dut (
        .fclk       (fclk),
        .rst        (rst),
        .en         (en),
        .line_busy  (line_busy),
        .cfg_req    (cfg_req),
        .cfg_sel    (cfg_sel),
        .cfg_ack    (cfg_ack),
        .tick_os    (tick_os),
        .tick_bit   (tick_bit),
        .cur_sel    (cur_sel),
        .cfg_forced (cfg_forced)
    );

    always #5 fclk = ~fclk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all(input string pfx);
        chk({pfx, "_tick_os"},  {7'd0, tick_os},    {7'd0, m_os});
        chk({pfx, "_tick_bit"}, {7'd0, tick_bit},   {7'd0, m_bit});
        chk({pfx, "_cfg_ack"},  {7'd0, cfg_ack},    {7'd0, m_ack});
        chk({pfx, "_cur_sel"},  {5'd0, cur_sel},    8'(m_sel));
        chk({pfx, "_forced"},   {7'd0, cfg_forced}, {7'd0, m_forced});
    endtask

    task automatic model_reset();
        m_phase       = 0;
        m_sel         = int'(SELR);
        m_pend        = int'(SELR);
        m_elapsed     = 0;
        m_bits_waited = 0;
        m_ack         = 1'b0;
        m_os          = 1'b0;
        m_bit         = 1'b0;
        m_forced      = 1'b0;
    endtask

    // Advance the model over one clock edge using the current inputs, then
    // let the edge happen and compare just after it.
    task automatic step();
        int period;
        period   = PRE * (2 << m_sel);
        m_forced = 1'b0;
        if (!en || m_phase == 2) begin
            m_elapsed = 0;
            m_os      = 1'b0;
            m_bit     = 1'b0;
        end else begin
            m_elapsed++;
            m_os  = (m_elapsed % period) == 0;
            m_bit = (m_elapsed % (period * OVSP)) == 0;
        end
        case (m_phase)
            0: begin
                if (cfg_req) begin
                    m_pend        = int'(cfg_sel);
                    m_phase       = 1;
                    m_bits_waited = 0;
                end
            end
            1: begin
                if (m_bit) m_bits_waited++;
                if (!line_busy) begin
                    m_phase = 2;
                end
`ifdef BRG_CTRL_TIMEOUT_EN
                else if (m_bits_waited == TOB) begin
                    m_phase  = 2;
                    m_forced = 1'b1;
                end
`endif
            end
            2: begin
                m_sel   = m_pend;
                m_phase = 3;
            end
            3: begin
                if (!cfg_req) m_phase = 0;
            end
            default: m_phase = 0;
        endcase
        m_ack = (m_phase == 3);
        @(posedge fclk);
        #1;
        chk_all("cyc");
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_ack(input string tag);
        for (int i = 0; i < 40 && !m_ack; i++) step();
        chk({tag, "_ack_seen"}, {7'd0, cfg_ack}, 8'd1);
    endtask

    // Reset asserted mid-cycle; outputs must change without a clock edge.
    task automatic do_reset();
        #3;
        rst     = 1'b1;
        cfg_req = 1'b0;
        #1;
        model_reset();
        chk_all("rst_async");
        @(posedge fclk);
        @(posedge fclk);
        #1;
        rst = 1'b0;
        chk_all("rst_hold");
    endtask

    initial begin
        int s;
        model_reset();
        do_reset();

        // default rate after reset: tick_os every 6, tick_bit every 48
        en = 1'b1;
        run(120);

        // reconfigure to select 2 on an idle line; sel changes afterwards are ignored
        cfg_sel = 3'd2;
        cfg_req = 1'b1;
        step();
        cfg_sel = 3'($urandom_range(0, 7));
        wait_ack("sel2");
        run($urandom_range(1, 5));
        cfg_req = 1'b0;
        run(420);
        chk("sel2_active", {5'd0, cur_sel}, 8'd2);

        // request deferred by a long busy frame
        line_busy = 1'b1;
        cfg_sel   = 3'($urandom_range(0, 1));
        cfg_req   = 1'b1;
        run(500);
        chk("busy_no_ack", {7'd0, cfg_ack}, 8'd0);
        line_busy = 1'b0;
        wait_ack("busy");
        cfg_req = 1'b0;
        run(100);

        // same select still goes through the full reload
        s       = m_sel;
        cfg_sel = 3'(s);
        cfg_req = 1'b1;
        wait_ack("same_sel");
        cfg_req = 1'b0;
        run(50);

        // enable dropped mid-bit, then restored
        run($urandom_range(3, 20));
        en = 1'b0;
        run(100);
        en = 1'b1;
        run(200);

        // randomized traffic with a well-behaved requester
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 59) == 0) en = ~en;
            if ($urandom_range(0, 19) == 0) line_busy = ~line_busy;
            if (!cfg_req && !m_ack && $urandom_range(0, 29) == 0) begin
                cfg_req = 1'b1;
                cfg_sel = 3'($urandom_range(0, 2));
            end else if (cfg_req && m_ack && $urandom_range(0, 3) == 0) begin
                cfg_req = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                cfg_sel = 3'($urandom_range(0, 7));
            end
            step();
        end
        en        = 1'b1;
        line_busy = 1'b0;
        if (cfg_req) begin
            wait_ack("rand_tail");
            cfg_req = 1'b0;
        end
        run(5);

        // back to select 0, then hold the line busy well past the timeout
        cfg_sel = 3'd0;
        cfg_req = 1'b1;
        wait_ack("to_prep");
        cfg_req = 1'b0;
        run(3);
        line_busy = 1'b1;
        cfg_sel   = 3'd1;
        cfg_req   = 1'b1;
        run(1000);
        line_busy = 1'b0;
        wait_ack("to_end");
        cfg_req = 1'b0;
        run(20);

        // reset while acknowledging a switch to select 5
        cfg_sel = 3'd5;
        cfg_req = 1'b1;
        wait_ack("sel5");
        run(3);
        chk("sel5_active", {5'd0, cur_sel}, 8'd5);
        do_reset();
        run(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/brg_ctrl.md
BRG_CTRL -- requirements
Module: brg_ctrl

Interface
REQ-001 SHALL have parameter PRE_DIV, default 3: fclk prescale ratio, legal range 2..15.
REQ-002 SHALL have parameter OVS, default 8: oversample ticks per bit, legal range 4..16.
REQ-003 SHALL have parameter SEL_RST, default 3'b000: baud select loaded at reset.
REQ-004 SHALL have parameter TIMEOUT_BITS, default 16: bit periods PEND waits before forcing (used only with macro).
REQ-005 SHALL have ports: fclk in 1, system clock; rst in 1, asynchronous active-high reset.
REQ-006 SHALL have ports: en in 1, tick generation enable; line_busy in 1, UART frame in progress.
REQ-007 SHALL have ports: cfg_req in 1, reconfigure request; cfg_sel in 3, requested baud select; cfg_ack out 1, request completed.
REQ-008 SHALL have ports: tick_os out 1, oversample enable pulse; tick_bit out 1, bit-period enable pulse; cur_sel out 3, active select; cfg_forced out 1, timeout-forced reload pulse.

Function
REQ-009 SHALL use fclk only; tick outputs are single-cycle clock enables, never derived clocks.
REQ-010 SHALL count prescaler 0..PRE_DIV-1; pre_tick when count = PRE_DIV-1.
REQ-011 SHALL count pre_ticks 0..(2<<cur_sel)-1; tick_os = pre_tick AND os count terminal; period PRE_DIV*(2<<cur_sel) fclk cycles.
REQ-012 SHALL count tick_os 0..OVS-1; tick_bit asserted coincident with the tick_os completing the count.
REQ-013 SHALL, with en=0, hold all three counters at zero and drive tick_os=tick_bit=0; first tick_os arrives PRE_DIV*(2<<cur_sel) cycles after en rises.
REQ-014 SHALL implement FSM RUN, PEND, RELOAD, ACK; FSM operates regardless of en.
REQ-015 SHALL, in RUN with cfg_req=1, latch cfg_sel into pend_sel and go to PEND; cfg_sel is ignored in all other states.
REQ-016 SHALL, in PEND, go to RELOAD the first cycle line_busy=0 (including the cycle after entry).
REQ-017 SHALL, in RELOAD (exactly one cycle), load cur_sel from pend_sel, clear all counters, suppress both ticks, then go to ACK.
REQ-018 SHALL, in ACK, hold cfg_ack=1 until cfg_req=0, then return to RUN (four-phase handshake); ticks run at the new rate during ACK.
REQ-019 SHALL perform full reload and handshake even when pend_sel equals cur_sel.
REQ-020 SHALL keep ticking at the old rate in PEND; line_busy rising in PEND delays RELOAD.

Reset
REQ-021 SHALL, on rst asserted at any time, asynchronously set state RUN, cur_sel=SEL_RST, pend_sel=SEL_RST, all counters 0, cfg_ack=0, tick_os=0, tick_bit=0, cfg_forced=0.
REQ-022 SHALL abort any pending request on reset; the requester must re-issue it.

Configuration
REQ-023 SHALL honour macro BRG_CTRL_TIMEOUT_EN: when defined, PEND counts tick_bit pulses and, after TIMEOUT_BITS of them with line_busy still 1, goes to RELOAD and pulses cfg_forced for one cycle in RELOAD.
REQ-024 SHALL, without BRG_CTRL_TIMEOUT_EN, wait in PEND indefinitely and tie cfg_forced to 0; port list is unchanged.

Structure
REQ-025 SHALL place SEL_W=3, OS_CNT_W=9, PRE_CNT_W=4, the FSM state encoding and default PRE_DIV/OVS constants in shared package brg_pkg.
REQ-026 SHALL implement the three counters as instances of one sub-module brg_div_cnt (inputs: count enable, synchronous clear, terminal value; output: terminal-tick pulse).

Verification
REQ-027 Reset, en=1, PRE_DIV=3, OVS=8, sel=0 -> tick_os every 6 cycles, tick_bit every 48 cycles; first tick_os at cycle 6.
REQ-028 cfg_req=1, cfg_sel=2, line_busy=0 -> RELOAD next cycle, cur_sel=2 the cycle after, cfg_ack held until req drops; tick_os every 24, tick_bit every 192.
REQ-029 cfg_req with line_busy=1 for 500 cycles -> old rate persists, no cfg_ack; line_busy falls -> RELOAD next cycle, ack follows.
REQ-030 rst pulsed while in ACK with cur_sel=5 -> outputs immediately at reset values, cur_sel=SEL_RST, cfg_ack=0.
REQ-031 en=0 for 100 cycles mid-bit, then en=1 -> no ticks while low; first tick_os exactly PRE_DIV*(2<<cur_sel) cycles after rise.
REQ-032 With BRG_CTRL_TIMEOUT_EN, TIMEOUT_BITS=16, line_busy stuck 1 -> cfg_forced pulse and reload after the 16th tick_bit; without the macro, stays in PEND and cfg_forced stays 0.
